// File: rtl/leading_zero_diff.sv
// Streaming leading-zero counter and magnitude comparator for two
// wide unsigned operands delivered MSW first, one word per accepted beat.
// Ports: iClk/iRst (async, active-high), iStart, iValid, iDataX/iDataY in;
// oReady, oBusy, oDone, oLzX, oLzY, oDiff, oXZero, oYZero, oCmp out.
module leading_zero_diff #(
  parameter  int WORD_W    = 32,
  parameter  int NUM_WORDS = 64,
  localparam int N         = WORD_W * NUM_WORDS,
  localparam int LEN_W     = $clog2(N + 1)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iValid,
  input  logic [WORD_W-1:0] iDataX,
  input  logic [WORD_W-1:0] iDataY,
  output logic              oReady,
  output logic              oBusy,
  output logic              oDone,
  output logic [LEN_W-1:0]  oLzX,
  output logic [LEN_W-1:0]  oLzY,
  output logic [LEN_W:0]    oDiff,
  output logic              oXZero,
  output logic              oYZero,
  output logic [1:0]        oCmp
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [LEN_W-1:0] WW = LEN_W'(WORD_W);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] accx_q, accx_d;
  logic [LEN_W-1:0] accy_q, accy_d;
  logic             seenx_q, seenx_d;
  logic             seeny_q, seeny_d;
  logic             dec_q, dec_d;
  logic [1:0]       cmp_q, cmp_d;
  logic [LEN_W-1:0] lzx_q, lzx_d;
  logic [LEN_W-1:0] lzy_q, lzy_d;
  logic [LEN_W:0]   diff_q, diff_d;
  logic             xz_q, xz_d;
  logic             yz_q, yz_d;
  logic [1:0]       rcmp_q, rcmp_d;

  // Priority encoder: leading zeros of a nonzero word, 0..WORD_W-1.
  function automatic logic [LEN_W-1:0] lzc(input logic [WORD_W-1:0] w);
    logic [LEN_W-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (!hit && !w[i]) n = n + 1'b1;
      else hit = 1'b1;
    end
    return n;
  endfunction

  logic             start;
  logic             beat;
  logic [LEN_W-1:0] stepx, stepy;
  logic [LEN_W-1:0] accx_nx, accy_nx;
  logic [1:0]       cmp_nx;

  always_comb begin
    start   = iStart && (state_q != S_RUN);
    beat    = iValid && (state_q == S_RUN);
    stepx   = seenx_q ? '0 : ((iDataX == '0) ? WW : lzc(iDataX));
    stepy   = seeny_q ? '0 : ((iDataY == '0) ? WW : lzc(iDataY));
    accx_nx = accx_q + stepx;
    accy_nx = accy_q + stepy;
    // First differing word decides the compare; later words cannot.
    cmp_nx  = cmp_q;
    if (!dec_q && (iDataX != iDataY))
      cmp_nx = (iDataX > iDataY) ? 2'b01 : 2'b10;

    state_d = state_q;
    cnt_d   = cnt_q;
    accx_d  = accx_q;
    accy_d  = accy_q;
    seenx_d = seenx_q;
    seeny_d = seeny_q;
    dec_d   = dec_q;
    cmp_d   = cmp_q;
    lzx_d   = lzx_q;
    lzy_d   = lzy_q;
    diff_d  = diff_q;
    xz_d    = xz_q;
    yz_d    = yz_q;
    rcmp_d  = rcmp_q;

    if (start) begin
      state_d = S_RUN;
      cnt_d   = '0;
      accx_d  = '0;
      accy_d  = '0;
      seenx_d = 1'b0;
      seeny_d = 1'b0;
      dec_d   = 1'b0;
      cmp_d   = 2'b00;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN: begin
          if (beat) begin
            cnt_d   = cnt_q + 1'b1;
            accx_d  = accx_nx;
            accy_d  = accy_nx;
            seenx_d = seenx_q || (iDataX != '0);
            seeny_d = seeny_q || (iDataY != '0);
            dec_d   = dec_q || (iDataX != iDataY);
            cmp_d   = cmp_nx;
            if (cnt_q == LAST) begin
              // Final word's contribution folds straight into the results.
              state_d = S_DONE;
              lzx_d   = accx_nx;
              lzy_d   = accy_nx;
              diff_d  = {1'b0, accy_nx} - {1'b0, accx_nx};
              xz_d    = (accx_nx == FULL);
              yz_d    = (accy_nx == FULL);
              rcmp_d  = cmp_nx;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      accx_q  <= '0;
      accy_q  <= '0;
      seenx_q <= 1'b0;
      seeny_q <= 1'b0;
      dec_q   <= 1'b0;
      cmp_q   <= 2'b00;
      lzx_q   <= '0;
      lzy_q   <= '0;
      diff_q  <= '0;
      xz_q    <= 1'b0;
      yz_q    <= 1'b0;
      rcmp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      accx_q  <= accx_d;
      accy_q  <= accy_d;
      seenx_q <= seenx_d;
      seeny_q <= seeny_d;
      dec_q   <= dec_d;
      cmp_q   <= cmp_d;
      lzx_q   <= lzx_d;
      lzy_q   <= lzy_d;
      diff_q  <= diff_d;
      xz_q    <= xz_d;
      yz_q    <= yz_d;
      rcmp_q  <= rcmp_d;
    end
  end

  assign oReady = (state_q == S_RUN);
  assign oBusy  = (state_q == S_RUN) || (state_q == S_DONE);
  assign oDone  = (state_q == S_DONE);
  assign oLzX   = lzx_q;
  assign oLzY   = lzy_q;
  assign oDiff  = diff_q;
  assign oXZero = xz_q;
  assign oYZero = yz_q;
  assign oCmp   = rcmp_q;

endmodule

// File: tb/tb_leading_zero_diff.sv
// Directed bench for leading_zero_diff: default 32x64 instance plus a
// small 8x4 instance sharing the clock and reset.
module tb_leading_zero_diff;

  localparam int W  = 32;
  localparam int NW = 64;
  localparam int N  = W * NW;
  localparam int L  = $clog2(N + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         start, valid;
  logic [W-1:0] dx, dy;
  logic         rdy, busy, done, xz, yz;
  logic [L-1:0] lzx, lzy;
  logic [L:0]   diff;
  logic [1:0]   cmp;

  logic         s_start, s_valid;
  logic [7:0]   s_dx, s_dy;
  logic         s_rdy, s_busy, s_done, s_xz, s_yz;
  logic [5:0]   s_lzx, s_lzy;
  logic [6:0]   s_diff;
  logic [1:0]   s_cmp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  leading_zero_diff u_dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iValid(valid),
    .iDataX(dx), .iDataY(dy), .oReady(rdy), .oBusy(busy),
    .oDone(done), .oLzX(lzx), .oLzY(lzy), .oDiff(diff),
    .oXZero(xz), .oYZero(yz), .oCmp(cmp)
  );

  leading_zero_diff #(.WORD_W(8), .NUM_WORDS(4)) u_small (
    .iClk(clk), .iRst(rst), .iStart(s_start), .iValid(s_valid),
    .iDataX(s_dx), .iDataY(s_dy), .oReady(s_rdy), .oBusy(s_busy),
    .oDone(s_done), .oLzX(s_lzx), .oLzY(s_lzy), .oDiff(s_diff),
    .oXZero(s_xz), .oYZero(s_yz), .oCmp(s_cmp)
  );

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    int           bub;
    logic [L-1:0] lzx;
    logic [L-1:0] lzy;
    logic [L:0]   diff;
    logic         xz;
    logic         yz;
    logic [1:0]   cmp;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_txn();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feeds words until oDone; counts edges after the start edge and bubbles.
  task automatic feed(input logic [N-1:0] x, input logic [N-1:0] y,
                      input int bub, input bit pulse,
                      output int edges, output int nbub);
    int b;
    b     = 0;
    edges = 0;
    nbub  = 0;
    while (!done && edges < 1000) begin
      valid = 1'b0;
      start = pulse && (edges == 10);
      if (b < NW) begin
        if (int'($urandom_range(99)) < bub) begin
          nbub++;
        end else begin
          valid = 1'b1;
          dx    = x[(NW-1-b)*W +: W];
          dy    = y[(NW-1-b)*W +: W];
        end
      end
      if (valid && rdy) b++;
      tick();
      edges++;
    end
    valid = 1'b0;
    start = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL timeout: oDone never rose");
    end
  endtask

  task automatic check_res(input string tag, input vec_t v);
    chk({tag, " lzx"},  64'(lzx),  64'(v.lzx));
    chk({tag, " lzy"},  64'(lzy),  64'(v.lzy));
    chk({tag, " diff"}, 64'(diff), 64'(v.diff));
    chk({tag, " xz"},   64'(xz),   64'(v.xz));
    chk({tag, " yz"},   64'(yz),   64'(v.yz));
    chk({tag, " cmp"},  64'(cmp),  64'(v.cmp));
  endtask

  initial begin
    int edges, nbub;
    logic [31:0] r;
    logic [N-1:0] ones;

    tbl[0] = '{x: '0, y: '0, bub: 0, lzx: 12'd2047, lzy: 12'd0,
               diff: 13'(-2047), xz: 1'b0, yz: 1'b0, cmp: 2'b10};
    tbl[0].x[0]   = 1'b1;
    tbl[0].y[N-1] = 1'b1;
    tbl[1] = '{x: '0, y: '0, bub: 0, lzx: 12'd2048, lzy: 12'd2048,
               diff: 13'd0, xz: 1'b1, yz: 1'b1, cmp: 2'b00};
    tbl[2] = '{x: '0, y: '0, bub: 30, lzx: 12'd16, lzy: 12'd15,
               diff: 13'(-1), xz: 1'b0, yz: 1'b0, cmp: 2'b10};
    for (int w = 0; w < NW - 1; w++) begin
      r = $urandom;
      tbl[2].x[w*W +: W] = r;
      tbl[2].y[w*W +: W] = r;
    end
    tbl[2].x[N-W +: W] = 32'h0000_FFFF;
    tbl[2].y[N-W +: W] = 32'h0001_0000;
    // X: word 1 = 0x00F00000 -> 32+8; Y: word 5 = 1 -> 160+31.
    tbl[3] = '{x: '0, y: '0, bub: 20, lzx: 12'd40, lzy: 12'd191,
               diff: 13'd151, xz: 1'b0, yz: 1'b0, cmp: 2'b01};
    tbl[3].x[N-2*W +: W] = 32'h00F0_0000;
    tbl[3].y[N-6*W +: W] = 32'h0000_0001;

    rst = 1'b1; start = 1'b0; valid = 1'b0; dx = '0; dy = '0;
    s_start = 1'b0; s_valid = 1'b0; s_dx = '0; s_dy = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset rdy",  64'(rdy),  64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset lzx",  64'(lzx),  64'd0);
    chk("reset diff", 64'(diff), 64'd0);
    chk("reset cmp",  64'(cmp),  64'd0);

    for (int i = 0; i < 4; i++) begin
      begin_txn();
      chk($sformatf("v%0d rdy", i), 64'(rdy), 64'd1);
      feed(tbl[i].x, tbl[i].y, tbl[i].bub, 1'b0, edges, nbub);
      chk($sformatf("v%0d edges", i), 64'(edges), 64'(NW + nbub));
      check_res($sformatf("v%0d", i), tbl[i]);
      tick();
      chk($sformatf("v%0d done pulse", i), 64'(done), 64'd0);
      chk($sformatf("v%0d hold lzx", i), 64'(lzx), 64'(tbl[i].lzx));
      tick();
    end

    // iStart during RUN is ignored.
    begin_txn();
    feed(tbl[3].x, tbl[3].y, 0, 1'b1, edges, nbub);
    chk("pulse edges", 64'(edges), 64'(NW));
    check_res("pulse", tbl[3]);

    // Back-to-back: iStart in the DONE cycle.
    begin_txn();
    chk("b2b rdy", 64'(rdy), 64'd1);
    chk("b2b hold lzx", 64'(lzx), 64'(tbl[3].lzx));
    feed(tbl[0].x, tbl[0].y, 0, 1'b0, edges, nbub);
    chk("b2b edges", 64'(edges), 64'(NW));
    check_res("b2b", tbl[0]);
    tick();

    // Reset after 30 accepted words.
    begin_txn();
    valid = 1'b1;
    dx = 32'h1234_5678;
    dy = 32'h0;
    for (int k = 0; k < 30; k++) tick();
    valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst rdy",  64'(rdy),  64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst lzx",  64'(lzx),  64'd0);
    chk("rst lzy",  64'(lzy),  64'd0);
    chk("rst diff", 64'(diff), 64'd0);
    chk("rst cmp",  64'(cmp),  64'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post rst rdy", 64'(rdy), 64'd0);
    ones = '1;
    begin_txn();
    feed(ones, ones, 0, 1'b0, edges, nbub);
    chk("ones lzx", 64'(lzx), 64'd0);
    chk("ones lzy", 64'(lzy), 64'd0);
    chk("ones cmp", 64'(cmp), 64'd0);
    chk("ones xz",  64'(xz),  64'd0);
    tick();

    // Small instance: X = 0x0001FFFF, Y = 0x00000080.
    begin
      logic [31:0] sx, sy;
      int se;
      sx = 32'h0001_FFFF;
      sy = 32'h0000_0080;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      se = 0;
      for (int b = 0; b < 4; b++) begin
        s_valid = 1'b1;
        s_dx = sx[(3-b)*8 +: 8];
        s_dy = sy[(3-b)*8 +: 8];
        tick();
        se++;
      end
      s_valid = 1'b0;
      chk("small done", 64'(s_done), 64'd1);
      chk("small lzx",  64'(s_lzx),  64'd15);
      chk("small lzy",  64'(s_lzy),  64'd24);
      chk("small diff", 64'(s_diff), 64'd9);
      chk("small cmp",  64'(s_cmp),  64'd1);
      chk("small edges", 64'(se), 64'd4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
